// File: rtl/ct_f_spsram_pkg.sv
// Shared types and helpers for the parametrised single-port SRAM wrapper.
// Holds the init/ready state enum and the per-slice write-enable decode.
// Pure declarations; no clocked logic lives here.
package ct_f_spsram_pkg;

  // Sweep clears the array after reset; READY serves normal accesses.
  typedef enum logic [0:0] {
    SP_INIT  = 1'b0,
    SP_READY = 1'b1
  } sp_state_e;

  // Upper bound on WIDTH; the decode helper works on vectors of this size.
  localparam int unsigned SP_MAX_W  = 512;
  localparam int unsigned SP_MAX_AW = 9;

  // One enable per slice. Only the MSB of each WEN slice is looked at, and
  // all controls are active low.
  function automatic logic [SP_MAX_W-1:0] slice_we(
    input logic [SP_MAX_W-1:0] wen,
    input logic                gwen,
    input logic                cen,
    input int unsigned         slice_w,
    input int unsigned         nslice
  );
    logic [SP_MAX_W-1:0]  w_en;
    logic [SP_MAX_AW-1:0] w_idx;
    logic [SP_MAX_AW-1:0] w_bit;
    w_en = '0;
    for (int unsigned s = 0; s < SP_MAX_W; s++) begin
      if (s < nslice) begin
        w_idx       = SP_MAX_AW'(s);
        w_bit       = SP_MAX_AW'(s * slice_w + slice_w - 1);
        w_en[w_idx] = ~cen & ~gwen & ~wen[w_bit];
      end
    end
    return w_en;
  endfunction

endpackage

// File: rtl/ct_f_spsram_slice.sv
// One SLICE_W-wide column of the array: synchronous write, registered read.
// Read data is write-first and lands one clock after the access edge.
// The read register holds its value whenever i_re is low.
module ct_f_spsram_slice #(
  parameter int unsigned SLICE_W = 42,
  parameter int unsigned DEPTH   = 256,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_re,
  input  logic               i_we,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [SLICE_W-1:0] i_d,
  output logic [SLICE_W-1:0] o_q
);

  logic [SLICE_W-1:0] r_mem [DEPTH];
  logic [SLICE_W-1:0] r_q;

  // Storage array: plain synchronous write, no reset so it maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_d;
    end
  end

  // Read register: new data wins on a same-cycle write, otherwise old contents.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_re) begin
      r_q <= i_we ? i_d : r_mem[i_addr];
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ct_f_spsram_param.sv
// Parametrised single-port SRAM with active-low CEN/GWEN/WEN macro interface.
// Read latency 1 cycle (2 with OUT_REG); optional post-reset clear sweep.
// No backpressure: requests while INIT_BUSY is high are silently dropped.
module ct_f_spsram_param
  import ct_f_spsram_pkg::*;
#(
  parameter int unsigned         WIDTH    = 84,
  parameter int unsigned         DEPTH    = 256,
  parameter int unsigned         SLICE_W  = 42,
  parameter int unsigned         OUT_REG  = 0,
  parameter int unsigned         INIT_EN  = 0,
  parameter logic [SLICE_W-1:0]  INIT_VAL = '0,
  localparam int unsigned        ADDR_W   = $clog2(DEPTH),
  localparam int unsigned        NSLICE   = WIDTH / SLICE_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] A,
  input  logic              CEN,
  input  logic              GWEN,
  input  logic [WIDTH-1:0]  WEN,
  input  logic [WIDTH-1:0]  D,
  output logic [WIDTH-1:0]  Q,
  output logic              INIT_BUSY
);

  if ((WIDTH % SLICE_W) != 0 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WIDTH > SP_MAX_W) begin : g_bad_cfg
    $error("ct_f_spsram_param: WIDTH must be a multiple of SLICE_W and DEPTH a power of two");
  end

  sp_state_e          r_state;
  sp_state_e          w_state_nxt;
  logic [ADDR_W-1:0]  r_cnt;
  logic [ADDR_W-1:0]  w_cnt_nxt;
  logic [ADDR_W-1:0]  r_addr_hold;
  logic               w_init_wr;
  logic               w_acc;
  logic [NSLICE-1:0]  w_sl_we;
  logic [ADDR_W-1:0]  w_addr;
  logic [WIDTH-1:0]   w_din;
  logic [WIDTH-1:0]   w_q_raw;

  // Nothing touches the array on a reset edge; the sweep starts on the first edge after release.
  assign w_init_wr = ~RST & (r_state == SP_INIT);
  assign w_acc     = ~RST & (r_state == SP_READY) & ~CEN;

  // Sweep writes every slice; a normal access writes only the enabled slices.
  always_comb begin
    w_sl_we = '0;
    w_addr  = r_addr_hold;
    w_din   = D;
    if (w_init_wr) begin
      w_sl_we = '1;
      w_addr  = r_cnt;
      w_din   = {NSLICE{INIT_VAL}};
    end else if (w_acc) begin
      w_sl_we = NSLICE'(slice_we(SP_MAX_W'(WEN), GWEN, CEN, SLICE_W, NSLICE));
      w_addr  = A;
    end
  end

  // State and sweep-counter registers; reset always restarts the sweep from word 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= (INIT_EN != 0) ? SP_INIT : SP_READY;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Sweep one word per cycle and leave INIT on the edge that writes the last word.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      SP_INIT: begin
        if (r_cnt == ADDR_W'(DEPTH - 1)) begin
          w_state_nxt = SP_READY;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = SP_READY;
      end
    endcase
  end

  // Idle cycles present the last accessed address to the array.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_addr_hold <= '0;
    end else if (w_acc) begin
      r_addr_hold <= A;
    end
  end

  assign INIT_BUSY = RST ? (INIT_EN != 0) : (r_state == SP_INIT);

  for (genvar s = 0; s < NSLICE; s++) begin : g_slice
    ct_f_spsram_slice #(
      .SLICE_W (SLICE_W),
      .DEPTH   (DEPTH)
    ) u_slice (
      .i_clk  (CLK),
      .i_rst  (RST),
      .i_re   (w_acc),
      .i_we   (w_sl_we[s]),
      .i_addr (w_addr),
      .i_d    (w_din[s*SLICE_W +: SLICE_W]),
      .o_q    (w_q_raw[s*SLICE_W +: SLICE_W])
    );
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [WIDTH-1:0] r_pipe;
    // Extra retiming stage; it simply follows the slice read registers.
    always_ff @(posedge CLK) begin
      if (RST) begin
        r_pipe <= '0;
      end else begin
        r_pipe <= w_q_raw;
      end
    end
    assign Q = r_pipe;
  end else begin : g_noreg
    assign Q = w_q_raw;
  end

endmodule

// File: tb/tb_ct_f_spsram_param.sv
// Bench for ct_f_spsram_param: default build, INIT-sweep build, OUT_REG build.
// Each access is scored against an array model of the memory contents.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_ct_f_spsram_param;

  localparam logic [83:0] ALL84  = {84{1'b1}};
  localparam logic [63:0] ALL64  = {64{1'b1}};
  localparam logic [83:0] INITW1 = {42'h2A, 42'h2A};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [83:0] rnd84();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[83:0];
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // default build: 84 x 256, two 42-bit slices
  logic        rst;
  logic [7:0]  a0;
  logic        cen0, gwen0, busy0;
  logic [83:0] wen0, d0, q0;
  ct_f_spsram_param u0 (
    .CLK(clk), .RST(rst), .A(a0), .CEN(cen0), .GWEN(gwen0),
    .WEN(wen0), .D(d0), .Q(q0), .INIT_BUSY(busy0)
  );

  // clear-sweep build: 84 x 16, fill 0x2A per slice
  logic        rst1;
  logic [3:0]  a1;
  logic        cen1, gwen1, busy1;
  logic [83:0] wen1, d1, q1;
  ct_f_spsram_param #(.DEPTH(16), .INIT_EN(1), .INIT_VAL(42'h2A)) u1 (
    .CLK(clk), .RST(rst1), .A(a1), .CEN(cen1), .GWEN(gwen1),
    .WEN(wen1), .D(d1), .Q(q1), .INIT_BUSY(busy1)
  );

  // registered-output build: 64 x 16, byte slices
  logic [3:0]  a2;
  logic        cen2, gwen2, busy2;
  logic [63:0] wen2, d2, q2;
  ct_f_spsram_param #(.WIDTH(64), .DEPTH(16), .SLICE_W(8), .OUT_REG(1)) u2 (
    .CLK(clk), .RST(rst), .A(a2), .CEN(cen2), .GWEN(gwen2),
    .WEN(wen2), .D(d2), .Q(q2), .INIT_BUSY(busy2)
  );

  logic [83:0] m0 [256];
  logic [83:0] e0;
  logic [83:0] m1 [16];
  logic [83:0] e1;
  logic [63:0] m2 [16];
  logic [63:0] rd2;   // word most recently read (what Q shows one cycle later)
  logic [63:0] e2;

  task automatic op0(input logic cen, input logic gwen, input logic [83:0] wen,
                     input logic [7:0] a, input logic [83:0] d, input string tag);
    cen0 = cen; gwen0 = gwen; wen0 = wen; a0 = a; d0 = d;
    @(posedge clk);
    if (!cen) begin
      for (int s = 0; s < 2; s++)
        if (!gwen && !wen[s*42+41]) m0[a][s*42 +: 42] = d[s*42 +: 42];
      e0 = m0[a];
    end
    @(negedge clk);
    check_eq(tag, q0, e0);
    cen0 = 1'b1;
  endtask

  task automatic op1(input logic cen, input logic gwen, input logic [83:0] wen,
                     input logic [3:0] a, input logic [83:0] d, input string tag);
    cen1 = cen; gwen1 = gwen; wen1 = wen; a1 = a; d1 = d;
    @(posedge clk);
    if (!cen) begin
      for (int s = 0; s < 2; s++)
        if (!gwen && !wen[s*42+41]) m1[a][s*42 +: 42] = d[s*42 +: 42];
      e1 = m1[a];
    end
    @(negedge clk);
    check_eq(tag, q1, e1);
    cen1 = 1'b1;
  endtask

  task automatic op2(input logic cen, input logic gwen, input logic [63:0] wen,
                     input logic [3:0] a, input logic [63:0] d, input string tag,
                     output logic [63:0] qs);
    cen2 = cen; gwen2 = gwen; wen2 = wen; a2 = a; d2 = d;
    @(posedge clk);
    e2 = rd2;
    if (!cen) begin
      for (int s = 0; s < 8; s++)
        if (!gwen && !wen[s*8+7]) m2[a][s*8 +: 8] = d[s*8 +: 8];
      rd2 = m2[a];
    end
    @(negedge clk);
    check_eq(tag, q2, e2);
    qs = q2;
    cen2 = 1'b1;
  endtask

  // Releases u1 from reset and measures how long INIT_BUSY stays up while
  // junk requests are driven; Q must read 0 throughout the sweep.
  task automatic run_sweep(input string tag);
    int n;
    n = 0;
    rst1 = 1'b0;
    for (int i = 0; i < 16; i++) m1[i] = INITW1;
    e1 = '0;
    while (busy1 && n < 100) begin
      n++;
      check_eq({tag, "_q_zero"}, q1, 0);
      cen1 = 1'b0; gwen1 = 1'b0; wen1 = '0; d1 = ALL84; a1 = 4'($urandom);
      @(negedge clk);
    end
    cen1 = 1'b1; gwen1 = 1'b1; wen1 = ALL84;
    check_eq({tag, "_busy_len"}, n, 16);
    for (int i = 0; i < 16; i++) begin
      op1(1'b0, 1'b1, ALL84, 4'(i), '0, {tag, "_rd"});
      check_eq({tag, "_fill"}, q1, INITW1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] obs [5];
    logic [63:0] v1, v2, v3, bd, wtmp;
    logic [83:0] w84;
    rst = 1'b1; rst1 = 1'b1;
    cen0 = 1'b1; gwen0 = 1'b1; wen0 = ALL84; d0 = '0; a0 = '0;
    cen1 = 1'b1; gwen1 = 1'b1; wen1 = ALL84; d1 = '0; a1 = '0;
    cen2 = 1'b1; gwen2 = 1'b1; wen2 = ALL64; d2 = '0; a2 = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_q0", q0, 0);
    check_eq("rst_busy0", busy0, 0);
    check_eq("rst_q1", q1, 0);
    check_eq("rst_busy1", busy1, 1);
    check_eq("rst_q2", q2, 0);
    rst = 1'b0;
    e0 = '0; rd2 = '0; e2 = '0;
    @(negedge clk);
    check_eq("ready_busy0", busy0, 0);

    // whole-word write then read back
    op0(1'b0, 1'b0, '0, 8'h05, ALL84, "t1_wr");
    op0(1'b0, 1'b1, ALL84, 8'h05, '0, "t1_rd");
    check_eq("t1_const", q0, ALL84);

    // only the low slice is enabled
    op0(1'b0, 1'b0, '0, 8'h10, '0, "t2_pre");
    w84 = ALL84; w84[41] = 1'b0;
    op0(1'b0, 1'b0, w84, 8'h10, ALL84, "t2_wr");
    op0(1'b0, 1'b1, ALL84, 8'h10, '0, "t2_rd");
    check_eq("t2_const", q0, {42'h0, {42{1'b1}}});

    // GWEN=0 with every used WEN bit high must not write
    w84 = '1; w84[41] = 1'b1; w84[83] = 1'b1;
    op0(1'b0, 1'b0, w84, 8'h10, '0, "t2_ro");
    check_eq("t2_ro_const", q0, {42'h0, {42{1'b1}}});

    // CEN high: Q holds, nothing is written despite write controls
    op0(1'b0, 1'b1, ALL84, 8'h05, '0, "t3_rd");
    for (int i = 0; i < 5; i++)
      op0(1'b1, 1'b0, '0, 8'($urandom), rnd84(), "t3_hold");
    check_eq("t3_hold_const", q0, ALL84);
    op0(1'b0, 1'b1, ALL84, 8'h05, '0, "t3_after");
    op0(1'b0, 1'b1, ALL84, 8'h10, '0, "t3_after10");

    // random traffic on a preloaded pool
    for (int i = 0; i < 16; i++) op0(1'b0, 1'b0, '0, 8'(8'h20 + i), rnd84(), "r0_pre");
    for (int i = 0; i < 150; i++)
      op0(($urandom_range(0, 3) == 0), 1'($urandom), rnd84(),
          8'(8'h20 + $urandom_range(0, 15)), rnd84(), "r0_op");

    // registered output: preload, then back-to-back reads
    for (int i = 0; i < 16; i++) op2(1'b0, 1'b0, '0, 4'(i), rnd64(), "o_pre", wtmp);
    v1 = m2[1]; v2 = m2[2]; v3 = m2[3];
    op2(1'b0, 1'b1, ALL64, 4'd1, '0, "o_rd1", obs[0]);
    op2(1'b0, 1'b1, ALL64, 4'd2, '0, "o_rd2", obs[1]);
    op2(1'b0, 1'b1, ALL64, 4'd3, '0, "o_rd3", obs[2]);
    op2(1'b1, 1'b1, ALL64, 4'd7, '0, "o_idle", obs[3]);
    op2(1'b1, 1'b1, ALL64, 4'd9, '0, "o_idle", obs[4]);
    check_eq("o_lat_a1", obs[1], v1);
    check_eq("o_lat_a2", obs[2], v2);
    check_eq("o_lat_a3", obs[3], v3);
    check_eq("o_hold_a3", obs[4], v3);

    // byte write through WEN[15] only
    bd = rnd64();
    wtmp = ALL64; wtmp[15] = 1'b0;
    op2(1'b0, 1'b0, wtmp, 4'd1, bd, "o_bw", obs[0]);
    op2(1'b0, 1'b1, ALL64, 4'd1, '0, "o_bw_rd", obs[1]);
    check_eq("o_bw_const", obs[1], (v1 & ~64'hFF00) | (bd & 64'hFF00));
    for (int i = 0; i < 150; i++)
      op2(($urandom_range(0, 3) == 0), 1'($urandom), rnd64(),
          4'($urandom), rnd64(), "r2_op", wtmp);

    // clear sweep after reset release, requests during it dropped
    run_sweep("t4");
    op1(1'b0, 1'b0, '0, 4'd3, ALL84, "t4_wr3");

    // reset in the middle of a sweep restarts it from word 0
    rst1 = 1'b1;
    repeat (2) @(negedge clk);
    rst1 = 1'b0;
    repeat (7) @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    check_eq("t5_rst_busy", busy1, 1);
    check_eq("t5_rst_q", q1, 0);
    @(negedge clk);
    run_sweep("t5");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
